cgra_col_mem_arbiter: RTL

Shares one OBI-style memory master port between the N_COL column data ports of the RC array. The column ports are the per-column req/wen/add/wdata outputs of the reconfigurable-cell array. Arbitration is round-robin with an address lock while a request waits for grant. An in-order outstanding-ID FIFO routes each returning rvalid/rdata back to the column that issued the access. The block sits between the RC array and the system bus master.

---
 rtl/cgra_pkg.sv | 37 +++
 rtl/cgra_col_mem_arbiter_if.sv | 23 ++
 rtl/cgra_id_fifo.sv | 67 ++++++
 rtl/cgra_col_mem_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// cgra_pkg: shared constants and helpers for the CGRA column memory arbiter.
//   N_COL           number of RC-array columns sharing the memory port
//   DP_WIDTH        address/data width
//   MEM_OUTST_DEPTH default depth of the outstanding-ID FIFO
//   ID_W            column ID width (at least 1)
package cgra_pkg;

    localparam int N_COL           = 4;
    localparam int DP_WIDTH        = 32;
    localparam int MEM_OUTST_DEPTH = 4;
    localparam int ID_W            = (N_COL > 1) ? $clog2(N_COL) : 1;

    // Arbiter holds the winner on the bus while the memory stalls.
    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin pick: first set request scanning upward from ptr, wrapping.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_COL-1:0] req,
                                               input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_COL; i++) begin
            idx = ID_W'((int'(ptr) + i) % N_COL);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cgra_col_mem_arbiter_if.sv
// cgra_col_mem_arbiter_if: OBI-style memory bus between the arbiter and the
// system bus master.
//   req/we/be/addr/wdata  request channel (arbiter -> bus)
//   gnt                   request accepted (bus -> arbiter)
//   rvalid/rdata          in-order response channel (bus -> arbiter)
interface cgra_col_mem_arbiter_if;
    import cgra_pkg::*;

    logic                  req;
    logic                  we;
    logic [DP_WIDTH/8-1:0] be;
    logic [DP_WIDTH-1:0]   addr;
    logic [DP_WIDTH-1:0]   wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DP_WIDTH-1:0]   rdata;

    modport master (output req, we, be, addr, wdata,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we, be, addr, wdata,
                    output gnt, rvalid, rdata);

endinterface

// File: rtl/cgra_id_fifo.sv
// cgra_id_fifo: synchronous FIFO of column IDs for in-order response routing.
//   clk_i/rst_ni      clock, asynchronous active-low reset
//   push_i/data_i     enqueue an ID (ignored while full)
//   pop_i/data_o      dequeue; data_o shows the head entry
//   full_o/empty_o    status flags
//   count_o           occupancy, 0..DEPTH
module cgra_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cgra_col_mem_arbiter.sv
// cgra_col_mem_arbiter: shares one OBI memory master port between the RC-array
// columns with round-robin arbitration, an address lock during bus stalls and
// in-order response routing through an outstanding-ID FIFO.
//   clk_i/rst_ni          clock, asynchronous active-low reset
//   col_req/wen/add/wdata per-column request channel (wen: 1=read, 0=write)
//   col_gnt_o             one-hot combinational grant
//   col_rvalid_o          one-hot response valid, col_rdata_o broadcast data
//   mem_bus               OBI master port
//   outst_cnt_o           outstanding transactions
//   err_o                 sticky protocol error
module cgra_col_mem_arbiter
    import cgra_pkg::*;
#(
    parameter int MAX_OUTST = MEM_OUTST_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_COL-1:0]               col_req_i,
    input  logic [N_COL-1:0]               col_wen_i,
    input  logic [N_COL-1:0][DP_WIDTH-1:0] col_add_i,
    input  logic [N_COL-1:0][DP_WIDTH-1:0] col_wdata_i,
    output logic [N_COL-1:0]               col_gnt_o,
    output logic [N_COL-1:0]               col_rvalid_o,
    output logic [DP_WIDTH-1:0]            col_rdata_o,
    cgra_col_mem_arbiter_if.master         mem_bus,
    output logic [$clog2(MAX_OUTST):0]     outst_cnt_o,
    output logic                           err_o
);
    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
    logic            err_q, err_d;
    logic [ID_W-1:0] winner, head_id;
    logic            fifo_full, fifo_empty;
    logic            mem_req, handshake, pop;

    // A locked winner is held on the bus even if its column dropped req.
    always_comb begin
        winner    = (state_q == ARB_LOCKED) ? lock_id_q : rr_pick(col_req_i, rr_ptr_q);
        mem_req   = ((state_q == ARB_LOCKED) | (|col_req_i)) & ~fifo_full;
        handshake = mem_req & mem_bus.gnt;
        pop       = mem_bus.rvalid & ~fifo_empty;
    end

    always_comb begin
        mem_bus.req   = mem_req;
        mem_bus.be    = '1;
        mem_bus.we    = 1'b0;
        mem_bus.addr  = '0;
        mem_bus.wdata = '0;
        col_gnt_o     = '0;
        col_rvalid_o  = '0;
        if (mem_req) begin
            mem_bus.we    = ~col_wen_i[winner];
            mem_bus.addr  = col_add_i[winner];
            mem_bus.wdata = col_wdata_i[winner];
        end
        col_gnt_o[winner]     = handshake;
        col_rvalid_o[head_id] = pop;
    end

    assign col_rdata_o = mem_bus.rdata;
    assign err_o       = err_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        err_d     = err_q;
        if (handshake) begin
            state_d  = ARB_FREE;
            rr_ptr_d = (winner == ID_W'(N_COL-1)) ? '0 : winner + ID_W'(1);
        end else if (mem_req) begin
            state_d   = ARB_LOCKED;
            lock_id_d = winner;
        end
        // Orphan response, or locked column withdrew its request.
        if (mem_bus.rvalid & fifo_empty) err_d = 1'b1;
        if ((state_q == ARB_LOCKED) & ~col_req_i[lock_id_q]) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_FREE;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    cgra_id_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (winner),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outst_cnt_o)
    );

endmodule
